// File: rtl/fpu_seq_pkg.sv
// Shared constants and state encoding for the sequential mantissa adder.
package fpu_seq_pkg;

  localparam int SLICE_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla6_slice.sv
// 6-bit carry-lookahead slice: every carry is formed directly from P, G
// and ci, so no carry ripples inside the slice.
module cla6_slice
  import fpu_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[0] = ci;
  assign w_c[1] = w_g[0]
                | (w_p[0] & ci);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (&w_p[1:0] & ci);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (&w_p[2:1] & w_g[0])
                | (&w_p[2:0] & ci);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (&w_p[3:2] & w_g[1])
                | (&w_p[3:1] & w_g[0])
                | (&w_p[3:0] & ci);
  assign w_c[5] = w_g[4]
                | (w_p[4] & w_g[3])
                | (&w_p[4:3] & w_g[2])
                | (&w_p[4:2] & w_g[1])
                | (&w_p[4:1] & w_g[0])
                | (&w_p[4:0] & ci);
  assign w_c[6] = w_g[5]
                | (w_p[5] & w_g[4])
                | (&w_p[5:4] & w_g[3])
                | (&w_p[5:3] & w_g[2])
                | (&w_p[5:2] & w_g[1])
                | (&w_p[5:1] & w_g[0])
                | (&w_p[5:0] & ci);

  assign s  = w_p ^ w_c[SLICE_W-1:0];
  assign co = w_c[SLICE_W];

endmodule

// File: rtl/mant_add_seq.sv
// Sequential WIDTH-bit mantissa adder reusing one 6-bit lookahead slice.
// Define MANT_SEQ_SUB_EN to add the sub port (A-B via stored ~B, carry 1).
module mant_add_seq
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MANT_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % SLICE_W != 0) begin : g_width_chk
    $error("mant_add_seq: WIDTH must be a multiple of 6");
  end

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [IW-1:0]      r_idx;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_ci_in;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;
  logic               w_accept;

`ifdef MANT_SEQ_SUB_EN
  assign w_b_in  = sub ? ~b : b;
  assign w_ci_in = sub | cin;
`else
  assign w_b_in  = b;
  assign w_ci_in = cin;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_carry;
  assign w_accept  = in_valid && in_ready;

  assign w_sa = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sb = r_b[r_idx*SLICE_W +: SLICE_W];

  cla6_slice u_slice (
    .a  (w_sa),
    .b  (w_sb),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (r_idx == LAST) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_ci_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
      r_carry <= w_co;
      if (r_idx != LAST) r_idx <= r_idx + 1'b1;
    end
  end

endmodule
